// File: rtl/seq_right_shifter_pkg.sv
// Shared types and width helper for the shifter family.
// The combinational left shifter derives its data width from shr_width() as well.
package shifter_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shr_state_t;

  localparam int unsigned DefaultN = 2;

  function automatic int unsigned shr_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/seq_right_shifter_if.sv
// Operand and result handshakes of the sequential right shifter.
// The producer/consumer side uses master; the shifter uses slave.
interface seq_right_shifter_if
  import shifter_pkg::*;
#(
  parameter int unsigned N = DefaultN
);

  localparam int unsigned W = shr_width(N);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [N-1:0] shamt;
  logic         arith;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;

  modport master (
    output in_valid, A, shamt, arith, out_ready,
    input  in_ready, out_valid, Y
  );

  modport slave (
    input  in_valid, A, shamt, arith, out_ready,
    output in_ready, out_valid, Y
  );

endinterface

// File: rtl/seq_right_shifter.sv
// Multi-cycle logical/arithmetic right shifter: one bit position per clock,
// operands in and results out on independent valid/ready handshakes.
module seq_right_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_right_shifter_if.slave  bus
);

  localparam int unsigned W = shr_width(N);

  shr_state_t   r_state, w_state;
  logic [W-1:0] r_sreg, w_sreg;
  logic [N-1:0] r_cnt, w_cnt;
  logic         r_mode, w_mode;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_fill;

  assign w_fill = r_mode & r_sreg[W-1];

  always_comb begin
    w_state     = r_state;
    w_sreg      = r_sreg;
    w_cnt       = r_cnt;
    w_mode      = r_mode;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_sreg  = bus.A;
          w_cnt   = bus.shamt;
          w_mode  = bus.arith;
          w_state = (bus.shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // cnt is at least 1 here, so the decrement never wraps
        w_sreg = {w_fill, r_sreg[W-1:1]};
        w_cnt  = r_cnt - N'(1);
        if (r_cnt == N'(1)) begin
          w_state = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sreg  <= w_sreg;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.Y         = r_sreg;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter (N=2): stimulus pushes hand-computed
// results into a scoreboard that a negedge monitor drains at each handoff.
module tb_seq_right_shifter;

  logic clk;
  logic rst_n;

  seq_right_shifter_if #(.N(2)) bus ();

  seq_right_shifter #(.N(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] sb[$];
  logic [3:0] trace[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: every handoff must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %0h expected none", bus.Y);
      end else begin
        check("result_Y", {28'd0, bus.Y}, {28'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Counts negedges until out_valid is seen; Y is traced while waiting.
  task automatic wait_valid(output int k);
    bit seen;
    k = 0;
    seen = 1'b0;
    trace.delete();
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) seen = 1'b1;
      else trace.push_back(bus.Y);
    end
  endtask

  task automatic do_op(input logic [3:0] a, input logic [1:0] sh, input logic ar,
                       input logic [3:0] exp_y);
    int k;
    bus.A         = a;
    bus.shamt     = sh;
    bus.arith     = ar;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    sb.push_back(exp_y);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_valid(k);
    check("latency", k, int'(sh) + 1);
    check("in_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready_after_handoff", {31'd0, bus.in_ready}, 32'd1);
    check("out_valid_after_handoff", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int k;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.shamt     = '0;
    bus.arith     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_Y", {28'd0, bus.Y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero shift, accepted on the first edge after reset release
    do_op(4'b1011, 2'd0, 1'b0, 4'b1011);

    // Logical maximum shift with intermediate values
    do_op(4'b1011, 2'd3, 1'b0, 4'b0001);
    check("trace_len", trace.size(), 32'd3);
    check("trace_shift1", {28'd0, trace[1]}, 32'h5);
    check("trace_shift2", {28'd0, trace[2]}, 32'h2);

    // Arithmetic
    do_op(4'b1011, 2'd2, 1'b1, 4'b1110);
    do_op(4'b0110, 2'd3, 1'b1, 4'b0000);

    // Backpressure: result held while new operands are offered
    bus.out_ready = 1'b0;
    bus.A         = 4'b0110;
    bus.shamt     = 2'd1;
    bus.arith     = 1'b0;
    bus.in_valid  = 1'b1;
    sb.push_back(4'b0011);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_valid(k);
    check("bp_latency", k, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.A        = 4'(i * 3 + 1);
      bus.shamt    = 2'(i);
      bus.arith    = i[0];
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_Y_stable", {28'd0, bus.Y}, 32'h3);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    check("bp_no_accept", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-shift aborts the operation
    bus.A        = 4'b1000;
    bus.shamt    = 2'd3;
    bus.arith    = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_Y", {28'd0, bus.Y}, 32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_result", {31'd0, bus.out_valid}, 32'd0);

    do_op(4'b1000, 2'd1, 1'b0, 4'b0100);
    // Sign fill across the full width
    do_op(4'b1000, 2'd3, 1'b1, 4'b1111);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
